arbitro_contador: RTL and testbench

//  Shares one 16-bit counter (CLK/ENB/MODO/D -> Q/RCO/Paridad) between two requesters.

---
 rtl/arbitro_pkg.sv | 27 ++
 rtl/arbitro_contador_if.sv | 32 +++
 rtl/arbitro_rr.sv | 39 +++
 rtl/arbitro_contador.sv | 169 ++++++++++++++++
 tb/tb_arbitro_contador.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_pkg.sv
// Shared constants for the two-requester counter arbiter: counter mode codes,
// controller state encoding and default widths.
package arbitro_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LEN_W = 8;

    localparam logic [1:0] MODO_UP    = 2'b00;
    localparam logic [1:0] MODO_DOWN  = 2'b01;
    localparam logic [1:0] MODO_DOWN3 = 2'b10;
    localparam logic [1:0] MODO_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Index of the set bit in a 2-bit one-hot vector.
    function automatic logic oh2_idx(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/arbitro_contador_if.sv
// Bus between the requesters/counter and the arbitration controller.
// The slave modport is the controller view; the master modport is the environment.
interface arbitro_contador_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
);
    logic [1:0]         REQ;
    logic [3:0]         CMD_MODO;
    logic [2*WIDTH-1:0] CMD_D;
    logic [2*LEN_W-1:0] CMD_LEN;
    logic [1:0]         GNT;
    logic               ENB;
    logic [1:0]         MODO;
    logic [WIDTH-1:0]   D;
    logic [WIDTH-1:0]   Q;
    logic               RCO;
    logic               BUSY;
    logic               DONE;
    logic               DONE_ID;
    logic [WIDTH-1:0]   RESULT;
    logic               RCO_SEEN;

    modport slave (
        input  REQ, CMD_MODO, CMD_D, CMD_LEN, Q, RCO,
        output GNT, ENB, MODO, D, BUSY, DONE, DONE_ID, RESULT, RCO_SEEN
    );

    modport master (
        output REQ, CMD_MODO, CMD_D, CMD_LEN, Q, RCO,
        input  GNT, ENB, MODO, D, BUSY, DONE, DONE_ID, RESULT, RCO_SEEN
    );
endinterface

// File: rtl/arbitro_rr.sv
// Two-way round-robin arbiter: combinational one-hot winner, last-served pointer
// updated on the strobe. After reset requester 0 wins a tie.
module arbitro_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] win_oh
);
    logic last_q;
    logic last_d;

    // Winner selection and pointer next-state
    always_comb begin
        win_oh = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   win_oh = 2'b01;
            2'b10:   win_oh = 2'b10;
            2'b11:   win_oh = last_q ? 2'b01 : 2'b10;
            default: win_oh = 2'b00;
        endcase
        if (upd && (req != 2'b00)) begin
            last_d = win_oh[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-served pointer; reset value 1 hands the first tie to requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/arbitro_contador.sv
// Sequencing controller sharing one counter between two requesters:
// grant, load, run N cycles in the requested mode, settle, report the captured Q.
module arbitro_contador
    import arbitro_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input logic               CLK,
    input logic               RESET_L,
    arbitro_contador_if.slave bus
);
    state_e             state_q, state_d;
    logic [1:0]         cmd_modo_q, cmd_modo_d;
    logic [WIDTH-1:0]   cmd_d_q, cmd_d_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               acc_q, acc_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               enb_q, enb_d;
    logic [1:0]         modo_q, modo_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               rco_seen_q, rco_seen_d;
    logic [1:0]         win_oh_s;
    logic               win_idx_s;
    logic               upd_s;

    arbitro_rr u_rr (
        .clk    (CLK),
        .rst_n  (RESET_L),
        .req    (bus.REQ),
        .upd    (upd_s),
        .win_oh (win_oh_s)
    );

    assign win_idx_s = oh2_idx(win_oh_s);

    // Next-state, command latch and registered-output decode
    always_comb begin
        state_d    = state_q;
        cmd_modo_d = cmd_modo_q;
        cmd_d_d    = cmd_d_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        acc_d      = acc_q;
        gnt_d      = 2'b00;
        result_d   = result_q;
        rco_seen_d = rco_seen_q;
        done_id_d  = done_id_q;
        upd_s      = 1'b0;
        enb_d      = 1'b0;
        modo_d     = MODO_UP;
        d_d        = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ != 2'b00) begin
                    state_d    = ST_GRANT;
                    upd_s      = 1'b1;
                    gnt_d      = win_oh_s;
                    id_d       = win_idx_s;
                    cmd_modo_d = win_idx_s ? bus.CMD_MODO[3:2] : bus.CMD_MODO[1:0];
                    cmd_d_d    = win_idx_s ? bus.CMD_D[2*WIDTH-1:WIDTH] : bus.CMD_D[WIDTH-1:0];
                    cnt_d      = win_idx_s ? bus.CMD_LEN[2*LEN_W-1:LEN_W] : bus.CMD_LEN[LEN_W-1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                acc_d   = 1'b0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // A pure load or a zero-length run has nothing to count
                if ((cnt_q == '0) || (cmd_modo_q == MODO_LOAD)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_q | bus.RCO;
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                // Capture here so RESULT/RCO_SEEN/DONE_ID are valid alongside DONE
                acc_d      = acc_q | bus.RCO;
                result_d   = bus.Q;
                rco_seen_d = acc_q | bus.RCO;
                done_id_d  = id_q;
                state_d    = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_LOAD) begin
            enb_d  = 1'b1;
            modo_d = MODO_LOAD;
            d_d    = cmd_d_q;
        end else if (state_d == ST_RUN) begin
            enb_d  = 1'b1;
            modo_d = cmd_modo_q;
            d_d    = cmd_d_q;
        end else begin
            enb_d  = 1'b0;
            modo_d = MODO_UP;
            d_d    = '0;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, command and output registers; reset abandons any command in flight
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= ST_IDLE;
            cmd_modo_q <= MODO_UP;
            cmd_d_q    <= '0;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            acc_q      <= 1'b0;
            gnt_q      <= 2'b00;
            enb_q      <= 1'b0;
            modo_q     <= MODO_UP;
            d_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            result_q   <= '0;
            rco_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_modo_q <= cmd_modo_d;
            cmd_d_q    <= cmd_d_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            acc_q      <= acc_d;
            gnt_q      <= gnt_d;
            enb_q      <= enb_d;
            modo_q     <= modo_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            result_q   <= result_d;
            rco_seen_q <= rco_seen_d;
        end
    end

    assign bus.GNT      = gnt_q;
    assign bus.ENB      = enb_q;
    assign bus.MODO     = modo_q;
    assign bus.D        = d_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.DONE_ID  = done_id_q;
    assign bus.RESULT   = result_q;
    assign bus.RCO_SEEN = rco_seen_q;

endmodule

// File: tb/tb_arbitro_contador.sv
// Directed bench for arbitro_contador driving a behavioural 16-bit counter.
module tb_arbitro_contador;

    logic        clk   = 1'b0;
    logic        rst_l = 1'b0;
    logic [15:0] cnt_tb = 16'h0000;
    int          vectors = 0;
    int          miscompares = 0;

    arbitro_contador_if #(.WIDTH(16), .LEN_W(8)) bus ();

    arbitro_contador #(.WIDTH(16), .LEN_W(8)) dut (
        .CLK     (clk),
        .RESET_L (rst_l),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Counter: 00 up, 01 down, 10 down by 3, 11 load D; no reset of its own
    always_ff @(posedge clk) begin
        if (bus.ENB) begin
            case (bus.MODO)
                2'b00:   cnt_tb <= cnt_tb + 16'd1;
                2'b01:   cnt_tb <= cnt_tb - 16'd1;
                2'b10:   cnt_tb <= cnt_tb - 16'd3;
                default: cnt_tb <= bus.D;
            endcase
        end
    end

    assign bus.Q   = cnt_tb;
    assign bus.RCO = bus.ENB && (((bus.MODO == 2'b00) && (cnt_tb == 16'hFFFF)) ||
                                 ((bus.MODO == 2'b01) && (cnt_tb == 16'h0000)) ||
                                 ((bus.MODO == 2'b10) && (cnt_tb <  16'h0003)));

    task automatic drive_cmd(input int r, input logic [1:0] m, input logic [15:0] dv, input logic [7:0] len);
        bus.CMD_MODO[2*r +: 2] = m;
        bus.CMD_D[16*r +: 16]  = dv;
        bus.CMD_LEN[8*r +: 8]  = len;
    endtask

    // Waits for a grant, then follows the command to DONE; only measures, never judges
    task automatic observe(input logic drop, output int gid, output int enb_n, output int enb_first,
                           output logic [1:0] enb_modo, output int done_off, output logic [15:0] res,
                           output logic rco, output logic did, output int viol, output logic tmo);
        logic seen;
        gid = -1; enb_n = 0; enb_first = -1; enb_modo = 2'b00; done_off = -1;
        res = 16'h0000; rco = 1'b0; did = 1'b0; viol = 0; tmo = 1'b1; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.GNT == 2'b11) viol++;
            if (bus.GNT != 2'b00) begin
                seen = 1'b1;
                gid  = bus.GNT[1] ? 1 : 0;
            end
        end
        if (seen) begin
            if (drop) bus.REQ[gid] = 1'b0;
            for (int k = 1; k <= 400 && tmo; k++) begin
                @(negedge clk);
                if (bus.GNT != 2'b00) viol++;
                if (!bus.ENB && ((bus.MODO != 2'b00) || (bus.D != 16'h0000))) viol++;
                if (bus.ENB) begin
                    if (enb_first < 0) begin
                        enb_first = k;
                        enb_modo  = bus.MODO;
                    end
                    enb_n++;
                end
                if (bus.DONE) begin
                    done_off = k; res = bus.RESULT; rco = bus.RCO_SEEN; did = bus.DONE_ID; tmo = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        bus.REQ = 2'($urandom_range(1, 3));
        repeat (2) @(negedge clk);
        vectors++; if (bus.GNT !== 2'b00) begin miscompares++; $display("FAIL rst_gnt got %b want 00", bus.GNT); end
        vectors++; if (bus.ENB !== 1'b0) begin miscompares++; $display("FAIL rst_enb got %b want 0", bus.ENB); end
        vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", bus.BUSY); end
        vectors++; if (bus.DONE !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", bus.DONE); end
        vectors++; if ({bus.MODO, bus.D, bus.DONE_ID, bus.RESULT, bus.RCO_SEEN} !== 36'h0) begin
            miscompares++; $display("FAIL rst_data got %h/%h/%b/%h/%b want all 0", bus.MODO, bus.D, bus.DONE_ID, bus.RESULT, bus.RCO_SEEN);
        end
        bus.REQ = 2'b00;
        rst_l = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if ({bus.BUSY, bus.ENB, bus.GNT} !== 4'b0000) begin
            miscompares++; $display("FAIL idle_after_rst got busy=%b enb=%b gnt=%b want 0", bus.BUSY, bus.ENB, bus.GNT);
        end
    endtask

    task automatic test_req0_up();
        int gid, en, ef, doff, viol; logic [1:0] em; logic [15:0] res; logic rco, did, tmo;
        drive_cmd(0, 2'b00, 16'h0010, 8'd5);
        bus.REQ = 2'b01;
        observe(1'b1, gid, en, ef, em, doff, res, rco, did, viol, tmo);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL t2_timeout got %b want 0", tmo); end
        vectors++; if (gid !== 0) begin miscompares++; $display("FAIL t2_gnt got %0d want 0", gid); end
        vectors++; if (ef !== 1 || en !== 6) begin miscompares++; $display("FAIL t2_enb got first=%0d n=%0d want 1/6", ef, en); end
        vectors++; if (doff !== 8) begin miscompares++; $display("FAIL t2_done_cycle got %0d want 8", doff); end
        vectors++; if (res !== 16'h0015) begin miscompares++; $display("FAIL t2_result got %h want 0015", res); end
        vectors++; if (rco !== 1'b0 || did !== 1'b0) begin miscompares++; $display("FAIL t2_rco_id got %b/%b want 0/0", rco, did); end
        vectors++; if (viol !== 0) begin miscompares++; $display("FAIL t2_invariants got %0d want 0", viol); end
        @(negedge clk);
        vectors++; if (bus.BUSY !== 1'b0 || bus.RESULT !== 16'h0015) begin
            miscompares++; $display("FAIL t2_after got busy=%b result=%h want 0/0015", bus.BUSY, bus.RESULT);
        end
    endtask

    task automatic test_req1_wrap();
        int gid, en, ef, doff, viol; logic [1:0] em; logic [15:0] res; logic rco, did, tmo;
        drive_cmd(1, 2'b00, 16'hFFFE, 8'd3);
        bus.REQ = 2'b10;
        observe(1'b1, gid, en, ef, em, doff, res, rco, did, viol, tmo);
        vectors++; if (tmo !== 1'b0 || gid !== 1) begin miscompares++; $display("FAIL t3_gnt got tmo=%b id=%0d want 0/1", tmo, gid); end
        vectors++; if (doff !== 6) begin miscompares++; $display("FAIL t3_done_cycle got %0d want 6", doff); end
        vectors++; if (res !== 16'h0001) begin miscompares++; $display("FAIL t3_result got %h want 0001", res); end
        vectors++; if (rco !== 1'b1 || did !== 1'b1) begin miscompares++; $display("FAIL t3_rco_id got %b/%b want 1/1", rco, did); end
    endtask

    task automatic test_load_only();
        int gid, en, ef, doff, viol; logic [1:0] em; logic [15:0] res; logic rco, did, tmo;
        drive_cmd(0, 2'b11, 16'hABCD, 8'd7);
        bus.REQ = 2'b01;
        observe(1'b1, gid, en, ef, em, doff, res, rco, did, viol, tmo);
        vectors++; if (tmo !== 1'b0 || gid !== 0) begin miscompares++; $display("FAIL t5_gnt got tmo=%b id=%0d want 0/0", tmo, gid); end
        vectors++; if (en !== 1 || em !== 2'b11) begin miscompares++; $display("FAIL t5_enb got n=%0d modo=%b want 1/11", en, em); end
        vectors++; if (doff !== 3) begin miscompares++; $display("FAIL t5_done_cycle got %0d want 3", doff); end
        vectors++; if (res !== 16'hABCD) begin miscompares++; $display("FAIL t5_result got %h want abcd", res); end
    endtask

    task automatic test_back_to_back();
        int gid, en, ef, doff, viol; logic [1:0] em; logic [15:0] res; logic rco, did, tmo;
        rst_l = 1'b0;
        bus.REQ = 2'b00;
        @(negedge clk);
        rst_l = 1'b1;
        drive_cmd(0, 2'b00, 16'h0100, 8'd2);
        drive_cmd(1, 2'b00, 16'h0200, 8'd2);
        bus.REQ = 2'b11;
        for (int i = 0; i < 4; i++) begin
            observe(1'b0, gid, en, ef, em, doff, res, rco, did, viol, tmo);
            vectors++; if (tmo !== 1'b0 || gid !== (i % 2)) begin
                miscompares++; $display("FAIL t4_order[%0d] got tmo=%b id=%0d want 0/%0d", i, tmo, gid, i % 2);
            end
            vectors++; if (res !== ((i % 2) ? 16'h0202 : 16'h0102) || viol !== 0) begin
                miscompares++; $display("FAIL t4_result[%0d] got %h viol=%0d want %h/0", i, res, viol, (i % 2) ? 16'h0202 : 16'h0102);
            end
        end
        bus.REQ = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int gid, en, ef, doff, viol, dones; logic [1:0] em; logic [15:0] res; logic rco, did, tmo, seen;
        drive_cmd(0, 2'b00, 16'h0000, 8'd200);
        bus.REQ = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.GNT != 2'b00) seen = 1'b1;
        end
        bus.REQ = 2'b00;
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL t6_gnt_timeout got %b want 1", seen); end
        repeat (10) @(negedge clk);
        vectors++; if (bus.ENB !== 1'b1) begin miscompares++; $display("FAIL t6_running got enb=%b want 1", bus.ENB); end
        rst_l = 1'b0;
        #1;
        vectors++; if (bus.ENB !== 1'b0 || bus.BUSY !== 1'b0) begin
            miscompares++; $display("FAIL t6_abort got enb=%b busy=%b want 0/0", bus.ENB, bus.BUSY);
        end
        dones = 0;
        repeat (2) begin @(negedge clk); if (bus.DONE) dones++; end
        rst_l = 1'b1;
        repeat (5) begin @(negedge clk); if (bus.DONE) dones++; end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL t6_no_done got %0d want 0", dones); end
        drive_cmd(1, 2'b01, 16'h0005, 8'd2);
        bus.REQ = 2'b10;
        observe(1'b1, gid, en, ef, em, doff, res, rco, did, viol, tmo);
        vectors++; if (tmo !== 1'b0 || gid !== 1 || doff !== 5) begin
            miscompares++; $display("FAIL t6_restart got tmo=%b id=%0d done=%0d want 0/1/5", tmo, gid, doff);
        end
        vectors++; if (res !== 16'h0003 || did !== 1'b1) begin
            miscompares++; $display("FAIL t6_result got %h id=%b want 0003/1", res, did);
        end
    endtask

    initial begin
        bus.REQ      = 2'b00;
        bus.CMD_MODO = 4'h0;
        bus.CMD_D    = 32'h0;
        bus.CMD_LEN  = 16'h0;
        test_reset();
        test_req0_up();
        test_req1_wrap();
        test_load_only();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
